// File: rtl/axil_lite_master.sv
// axil_lite_master: single-outstanding AXI4-Lite initiator fed by a valid/ready command port.
// Optional per-transaction abort timer is built only when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  busy,
  output logic [7:0]            txn_count
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_d;
  logic                    rsp_valid_d, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic [1:0]              rsp_resp_d;
  logic [ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    wr_q, wr_d;
  logic [7:0]              txn_count_d;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        resp_hs;
`endif

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      m_awaddr  <= '0;
      m_araddr  <= '0;
      m_wdata   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_q      <= 1'b0;
      txn_count <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_write <= rsp_write_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
      m_awaddr  <= awaddr_d;
      m_araddr  <= araddr_d;
      m_wdata   <= wdata_d;
      m_awvalid <= awvalid_d;
      m_wvalid  <= wvalid_d;
      m_bready  <= bready_d;
      m_arvalid <= arvalid_d;
      m_rready  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_q      <= wr_d;
      txn_count <= txn_count_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // Every output is a register; this block only computes the value each one takes next.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    awaddr_d    = m_awaddr;
    araddr_d    = m_araddr;
    wdata_d     = m_wdata;
    awvalid_d   = m_awvalid;
    wvalid_d    = m_wvalid;
    bready_d    = m_bready;
    arvalid_d   = m_arvalid;
    rready_d    = m_rready;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    wr_d        = wr_q;
    txn_count_d = txn_count;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          wr_d        = cmd_write;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      // AW and W complete independently, in either order.
      WR_REQ: begin
        if (m_awvalid && m_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (m_wvalid && m_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_bready && m_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_bresp;
          state_d     = RESP;
        end
      end

      RD_REQ: begin
        if (m_arvalid && m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_rready && m_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_rdata;
          rsp_resp_d  = m_rresp;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_count_d = txn_count + 8'd1;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    // A B/R handshake landing on the expiry cycle wins over the abort.
    resp_hs   = (m_bready && m_bvalid) || (m_rready && m_rvalid);
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (state_q != RESP) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
      if (tmo_cnt_q == TMO_LAST && !resp_hs) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = wr_q;
        rsp_rdata_d = '0;
        rsp_resp_d  = 2'b10;
        state_d     = RESP;
      end
    end
`endif
  end

endmodule

// File: tb/tb_axil_lite_master.sv
// Self-checking bench for axil_lite_master: a randomised AXI4-Lite responder and a transaction-level
// expectation model. The abort-timer scenario runs only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_lite_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]    m_bresp, m_rresp;
  logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic          busy;
  logic [7:0]    txn_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axil_lite_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .txn_count(txn_count)
  );

  // Responder: each ready rises after a programmable number of stalled cycles; B/R follow a cycle later.
  int unsigned   aw_delay, w_delay, ar_delay;
  logic          b_hold, ar_never, spur_v;
  logic [1:0]    cfg_bresp, cfg_rresp;
  logic [DW-1:0] cfg_rdata;
  int unsigned   aw_cnt, w_cnt, ar_cnt;
  int unsigned   aw_hi, w_hi, ar_hi, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic          aw_got, w_got, ar_got, bv, rv;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q, w_seen;
  logic [AW-1:0] aw_seen, ar_seen;

  assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
  assign m_wready  = m_wvalid && (w_cnt >= w_delay);
  assign m_arready = m_arvalid && !ar_never && (ar_cnt >= ar_delay);
  assign m_bvalid  = bv | spur_v;
  assign m_bresp   = bresp_q;
  assign m_rvalid  = rv | spur_v;
  assign m_rresp   = rresp_q;
  assign m_rdata   = rdata_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_hi <= 0; w_hi <= 0; ar_hi <= 0;
      aw_hs <= 0; w_hs <= 0; ar_hs <= 0; b_hs <= 0; r_hs <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; bv <= 1'b0; rv <= 1'b0;
      bresp_q <= 2'b00; rresp_q <= 2'b00; rdata_q <= '0;
      aw_seen <= '0; ar_seen <= '0; w_seen <= '0;
    end else begin
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      if (m_awvalid) aw_hi <= aw_hi + 1;
      if (m_wvalid)  w_hi  <= w_hi + 1;
      if (m_arvalid) ar_hi <= ar_hi + 1;
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_seen <= m_awaddr; aw_hs <= aw_hs + 1; end
      if (m_wvalid && m_wready)   begin w_got <= 1'b1; w_seen <= m_wdata; w_hs <= w_hs + 1; end
      if (m_arvalid && m_arready) begin ar_got <= 1'b1; ar_seen <= m_araddr; ar_hs <= ar_hs + 1; end
      if (aw_got && w_got && !bv && !b_hold) begin
        bv <= 1'b1; bresp_q <= cfg_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (ar_got && !rv) begin
        rv <= 1'b1; rresp_q <= cfg_rresp; rdata_q <= cfg_rdata; ar_got <= 1'b0;
      end
      if (bv && m_bready) begin bv <= 1'b0; b_hs <= b_hs + 1; end
      if (rv && m_rready) begin rv <= 1'b0; r_hs <= r_hs + 1; end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_write, rsp_resp, m_awvalid, m_wvalid,
                          m_bready, m_arvalid, m_rready, busy, txn_count}, 64'd0);
    check({tag, "_addr"}, {m_awaddr, m_araddr}, 64'd0);
    check({tag, "_data"}, {rsp_rdata, m_wdata}, 64'd0);
  endtask

  // One full command/response exchange; called and returns on a falling edge.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int unsigned awd, input int unsigned wd, input int unsigned ard,
                        input logic [1:0] resp, input logic [DW-1:0] rdat, input int unsigned hold);
    logic [34:0] exp_rsp;
    int unsigned aw_hi0, w_hi0, ar_hi0, aw_hs0, w_hs0, ar_hs0, b_hs0, r_hs0, j;
    aw_delay = awd; w_delay = wd; ar_delay = ard;
    cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = rdat;
    exp_rsp = wr ? {1'b1, {DW{1'b0}}, resp} : {1'b0, rdat, resp};
    aw_hi0 = aw_hi; w_hi0 = w_hi; ar_hi0 = ar_hi;
    aw_hs0 = aw_hs; w_hs0 = w_hs; ar_hs0 = ar_hs; b_hs0 = b_hs; r_hs0 = r_hs;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    j = 0;
    while (!cmd_ready && j < 20) begin @(negedge clk); j++; end
    if (!cmd_ready) begin
      check("accept_wait", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    check("req_valids", {m_awvalid, m_wvalid, m_arvalid, cmd_ready, busy}, wr ? 5'b11001 : 5'b00101);
    j = 0;
    while (!rsp_valid && j < 40) begin @(negedge clk); j++; end
    if (!rsp_valid) begin
      check("rsp_wait", 64'd0, 64'd1);
      return;
    end
    if (awd == 0 && wd == 0 && ard == 0) check("latency", j, 3);
    check("rsp_fields", {rsp_write, rsp_rdata, rsp_resp}, exp_rsp);
    if (wr) begin
      check("awaddr", aw_seen, addr);
      check("wdata", w_seen, data);
      check("aw_cycles", aw_hi - aw_hi0, awd + 1);
      check("w_cycles", w_hi - w_hi0, wd + 1);
      check("wr_handshakes", (aw_hs - aw_hs0) * 100 + (w_hs - w_hs0) * 10 + (b_hs - b_hs0), 111);
    end else begin
      check("araddr", ar_seen, addr);
      check("ar_cycles", ar_hi - ar_hi0, ard + 1);
      check("rd_handshakes", (ar_hs - ar_hs0) * 10 + (r_hs - r_hs0), 11);
    end
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp}, {2'b10, exp_rsp});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_done++;
    check("post_rsp", {rsp_valid, cmd_ready, busy, txn_count}, {3'b010, 8'(n_done % 256)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  int unsigned j_main;
  int unsigned ar_hi_main;
  logic        rnd_wr;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; aw_delay = 0; w_delay = 0; ar_delay = 0;
    b_hold = 1'b0; ar_never = 1'b0; spur_v = 1'b0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    check("cmd_ready_at_release", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_after_release", cmd_ready, 1);

    do_txn(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 0, 0, 0, 2'b00, '0, 0);
    do_txn(1'b0, 32'h0000_0010, '0, 0, 0, 0, 2'b00, 32'hA5A5_A5A4, 0);
    do_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 3, 0, 0, 2'b00, '0, 0);
    do_txn(1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 0, 2, 0, 2'b10, '0, 0);
    do_txn(1'b0, 32'h0000_0028, '0, 0, 0, 2, 2'b11, 32'h0BAD_F00D, 0);
    do_txn(1'b0, 32'h0000_0030, '0, 0, 0, 0, 2'b00, 32'h5555_AAAA, 5);

    // Unsolicited B/R valids while idle must never be accepted.
    spur_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spurious_ignored", {m_bready, m_rready, rsp_valid, busy, cmd_ready}, 5'b00001);
    end
    spur_v = 1'b0;
    @(negedge clk);

    while (n_done < 256) begin
      rnd_wr = 1'($urandom_range(0, 1));
      do_txn(rnd_wr, $urandom & 32'hFFFF_FFFC, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3));
    end
    check("txn_count_wrap", txn_count, 0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    ar_never = 1'b1;
    ar_hi_main = ar_hi;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
    @(negedge clk);
    cmd_valid = 1'b0;
    j_main = 0;
    while (!rsp_valid && j_main < 40) begin @(negedge clk); j_main++; end
    check("tmo_ar_cycles", ar_hi - ar_hi_main, 8);
    check("tmo_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, m_arvalid}, {2'b10, 32'h0, 2'b10, 1'b0});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_done++;
    check("tmo_txn_count", txn_count, n_done % 256);
    ar_never = 1'b0;
`endif

    // Reset while waiting on B: everything drops at once and the write is dropped.
    b_hold = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0080; cmd_wdata = 32'h0000_0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("in_wr_resp", {m_bready, busy, m_awvalid, m_wvalid}, 4'b1100);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0; b_hold = 1'b0; n_done = 0;
    check("ready_low_at_release", cmd_ready, 0);
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);
    j_main = 0;
    repeat (4) begin
      if (rsp_valid) j_main++;
      @(negedge clk);
    end
    check("no_stale_rsp", j_main, 0);
    do_txn(1'b1, 32'h0000_00FC, 32'hCAFE_0001, 0, 0, 0, 2'b00, '0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
